// File: rtl/banked_memory_bus.sv
// banked_memory_bus: bridges a single CPU request port onto NUM_BANKS memory banks.
// The top BANK_BITS address bits pick the bank. The remaining bits form the in-bank address.
// Banks flagged in WAIT_MASK complete through bank_ready and can time out.
// All other banks complete in a fixed single ACCESS cycle.
// Ports:
//   clk, reset (async active-low)
//   bus_enable, write_enable, address, data_in : CPU request, sampled in IDLE
//   data_out, ready, timeout_error, clear_error : CPU response / sticky error
//   bank_select, bank_write_enable              : one-hot bank strobes
//   bank_address, bank_data_in                  : latched request toward banks
//   bank_data_out, bank_ready                   : per-bank read data / completion
module banked_memory_bus #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANK_BITS  = 2,
  parameter logic [(2**BANK_BITS)-1:0] WAIT_MASK = 4'b1000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   bus_enable,
  input  logic                                   write_enable,
  input  logic [ADDR_WIDTH-1:0]                  address,
  input  logic [DATA_WIDTH-1:0]                  data_in,
  output logic [DATA_WIDTH-1:0]                  data_out,
  output logic                                   ready,
  output logic                                   timeout_error,
  input  logic                                   clear_error,
  output logic [(2**BANK_BITS)-1:0]              bank_select,
  output logic [(2**BANK_BITS)-1:0]              bank_write_enable,
  output logic [ADDR_WIDTH-BANK_BITS-1:0]        bank_address,
  output logic [DATA_WIDTH-1:0]                  bank_data_in,
  input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0]   bank_data_out,
  input  logic [(2**BANK_BITS)-1:0]              bank_ready
);

  localparam int unsigned NUM_BANKS  = 2**BANK_BITS;
  localparam int unsigned OFF_WIDTH  = ADDR_WIDTH - BANK_BITS;
  localparam int unsigned CNT_WIDTH  = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [BANK_BITS-1:0]   bank_q, bank_d;
  logic                   write_q, write_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [OFF_WIDTH-1:0]   bank_address_q, bank_address_d;
  logic [DATA_WIDTH-1:0]  bank_data_in_q, bank_data_in_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   ready_q, ready_d;
  logic                   timeout_error_q, timeout_error_d;
  logic [NUM_BANKS-1:0]   bank_select_q, bank_select_d;
  logic [NUM_BANKS-1:0]   bank_write_enable_q, bank_write_enable_d;

  logic [BANK_BITS-1:0]   req_bank;
  logic [NUM_BANKS-1:0]   cur_onehot;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   timeout_set;

  assign req_bank   = address[ADDR_WIDTH-1 -: BANK_BITS];
  assign cur_onehot = NUM_BANKS'(1) << bank_q;
  assign rd_data    = bank_data_out[bank_q*DATA_WIDTH +: DATA_WIDTH];

  // Next-state and registered-output logic; strobes are computed for the upcoming state.
  always_comb begin
    state_d             = state_q;
    bank_d              = bank_q;
    write_d             = write_q;
    cnt_d               = cnt_q;
    bank_address_d      = bank_address_q;
    bank_data_in_d      = bank_data_in_q;
    data_out_d          = data_out_q;
    timeout_error_d     = timeout_error_q;
    ready_d             = 1'b0;
    bank_select_d       = '0;
    bank_write_enable_d = '0;
    timeout_set         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus_enable) begin
          bank_d              = req_bank;
          bank_address_d      = address[OFF_WIDTH-1:0];
          bank_data_in_d      = data_in;
          write_d             = write_enable;
          bank_select_d       = NUM_BANKS'(1) << req_bank;
          bank_write_enable_d = write_enable ? (NUM_BANKS'(1) << req_bank) : '0;
          state_d             = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // bank_ready is deliberately not looked at here
        if (!WAIT_MASK[bank_q]) begin
          if (!write_q) data_out_d = rd_data;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d               = '0;
          bank_select_d       = cur_onehot;
          bank_write_enable_d = write_q ? cur_onehot : '0;
          state_d             = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ready in the final counted cycle still wins over the timeout
        if (bank_ready[bank_q]) begin
          if (!write_q) data_out_d = rd_data;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          if (!write_q) data_out_d = '1;
          timeout_set = 1'b1;
          ready_d     = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d               = cnt_q + CNT_WIDTH'(1);
          bank_select_d       = cur_onehot;
          bank_write_enable_d = write_q ? cur_onehot : '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Sticky error: a new timeout overrides a simultaneous clear
    if (clear_error) timeout_error_d = 1'b0;
    if (timeout_set) timeout_error_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= S_IDLE;
      bank_q              <= '0;
      write_q             <= 1'b0;
      cnt_q               <= '0;
      bank_address_q      <= '0;
      bank_data_in_q      <= '0;
      data_out_q          <= '0;
      ready_q             <= 1'b0;
      timeout_error_q     <= 1'b0;
      bank_select_q       <= '0;
      bank_write_enable_q <= '0;
    end else begin
      state_q             <= state_d;
      bank_q              <= bank_d;
      write_q             <= write_d;
      cnt_q               <= cnt_d;
      bank_address_q      <= bank_address_d;
      bank_data_in_q      <= bank_data_in_d;
      data_out_q          <= data_out_d;
      ready_q             <= ready_d;
      timeout_error_q     <= timeout_error_d;
      bank_select_q       <= bank_select_d;
      bank_write_enable_q <= bank_write_enable_d;
    end
  end

  assign data_out          = data_out_q;
  assign ready             = ready_q;
  assign timeout_error     = timeout_error_q;
  assign bank_select       = bank_select_q;
  assign bank_write_enable = bank_write_enable_q;
  assign bank_address      = bank_address_q;
  assign bank_data_in      = bank_data_in_q;

endmodule

// File: tb/tb_banked_memory_bus.sv
// Directed bench for banked_memory_bus.
// dut_a uses the default parameters.
// dut_b uses TIMEOUT=4 and carries the timeout scenarios.
module tb_banked_memory_bus;

  logic        clk;
  logic        reset;
  logic        bus_enable_a, bus_enable_b;
  logic        write_enable;
  logic [15:0] address;
  logic [7:0]  data_in;
  logic        clear_error;
  logic [31:0] bank_data_out;
  logic [3:0]  bank_ready;

  logic [7:0]  data_out_a, data_out_b;
  logic        ready_a, ready_b;
  logic        err_a, err_b;
  logic [3:0]  sel_a, sel_b, we_a, we_b;
  logic [13:0] baddr_a, baddr_b;
  logic [7:0]  bdin_a, bdin_b;

  int n_cmp = 0;
  int n_err = 0;

  banked_memory_bus dut_a (
    .clk(clk), .reset(reset), .bus_enable(bus_enable_a), .write_enable(write_enable),
    .address(address), .data_in(data_in), .data_out(data_out_a), .ready(ready_a),
    .timeout_error(err_a), .clear_error(clear_error), .bank_select(sel_a),
    .bank_write_enable(we_a), .bank_address(baddr_a), .bank_data_in(bdin_a),
    .bank_data_out(bank_data_out), .bank_ready(bank_ready)
  );

  banked_memory_bus #(.TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .bus_enable(bus_enable_b), .write_enable(write_enable),
    .address(address), .data_in(data_in), .data_out(data_out_b), .ready(ready_b),
    .timeout_error(err_b), .clear_error(clear_error), .bank_select(sel_b),
    .bank_write_enable(we_b), .bank_address(baddr_b), .bank_data_in(bdin_b),
    .bank_data_out(bank_data_out), .bank_ready(bank_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b0;
    bus_enable_a  = 1'b0;
    bus_enable_b  = 1'b0;
    write_enable  = 1'b0;
    address       = '0;
    data_in       = '0;
    clear_error   = 1'b0;
    bank_ready    = '0;
    bank_data_out = {8'h66, 8'h22, 8'h11, 8'hA5};

    // Reset values
    step();
    chk("rst_data_out", 32'(data_out_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_sel", 32'(sel_a), 32'h0);
    chk("rst_we", 32'(we_a), 32'h0);
    chk("rst_baddr", 32'(baddr_a), 32'h0);
    chk("rst_bdin", 32'(bdin_a), 32'h0);
    reset = 1'b1;
    step();

    // Fast read of bank 0
    bus_enable_a = 1'b1; write_enable = 1'b0; address = 16'h0012;
    step();
    chk("rd0_sel", 32'(sel_a), 32'h1);
    chk("rd0_ready_access", 32'(ready_a), 32'h0);
    bus_enable_a = 1'b0;
    step();
    chk("rd0_ready", 32'(ready_a), 32'h1);
    chk("rd0_data", 32'(data_out_a), 32'hA5);
    chk("rd0_sel_done", 32'(sel_a), 32'h0);
    chk("rd0_baddr", 32'(baddr_a), 32'h0012);
    step();
    chk("rd0_ready_drop", 32'(ready_a), 32'h0);

    // Write to bank 2
    bus_enable_a = 1'b1; write_enable = 1'b1; address = 16'h8003; data_in = 8'h3C;
    step();
    chk("wr2_we", 32'(we_a), 32'h4);
    chk("wr2_sel", 32'(sel_a), 32'h4);
    chk("wr2_baddr", 32'(baddr_a), 32'h0003);
    chk("wr2_bdin", 32'(bdin_a), 32'h3C);
    bus_enable_a = 1'b0; write_enable = 1'b0;
    step();
    chk("wr2_ready", 32'(ready_a), 32'h1);
    chk("wr2_we_done", 32'(we_a), 32'h0);
    chk("wr2_data_hold", 32'(data_out_a), 32'hA5);
    step();

    // Waited read of bank 3 with bank_ready in the fifth WAIT cycle
    bus_enable_a = 1'b1; address = 16'hC005;
    step();
    chk("rd3_sel_access", 32'(sel_a), 32'h8);
    bus_enable_a = 1'b0;
    bank_ready = 4'b1000;
    step();
    chk("rd3_ready_ignored_in_access", 32'(ready_a), 32'h0);
    bank_ready = 4'b0111;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rd3_sel_wait%0d", i), 32'(sel_a), 32'h8);
      chk($sformatf("rd3_ready_wait%0d", i), 32'(ready_a), 32'h0);
      step();
    end
    chk("rd3_sel_wait5", 32'(sel_a), 32'h8);
    bank_ready = 4'b1000;
    bank_data_out[31:24] = 8'h77;
    step();
    chk("rd3_ready", 32'(ready_a), 32'h1);
    chk("rd3_data", 32'(data_out_a), 32'h77);
    chk("rd3_err", 32'(err_a), 32'h0);
    chk("rd3_sel_done", 32'(sel_a), 32'h0);
    bank_ready = 4'b0000;
    step();
    chk("rd3_ready_drop", 32'(ready_a), 32'h0);

    // Timeout read on dut_b (TIMEOUT=4)
    bus_enable_b = 1'b1; address = 16'hC000;
    step();
    bus_enable_b = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_ready_wait%0d", i), 32'(ready_b), 32'h0);
      chk($sformatf("to_sel_wait%0d", i), 32'(sel_b), 32'h8);
      step();
    end
    chk("to_ready", 32'(ready_b), 32'h1);
    chk("to_data", 32'(data_out_b), 32'hFF);
    chk("to_err", 32'(err_b), 32'h1);
    step();
    chk("to_err_sticky", 32'(err_b), 32'h1);
    clear_error = 1'b1;
    step();
    chk("to_err_cleared", 32'(err_b), 32'h0);
    clear_error = 1'b0;

    // bank_ready in the last counted cycle counts as success
    bank_data_out[31:24] = 8'h5A;
    bus_enable_b = 1'b1; address = 16'hC001;
    step();
    bus_enable_b = 1'b0;
    step();
    step();
    step();
    step();
    bank_ready = 4'b1000;
    step();
    chk("edge_ready", 32'(ready_b), 32'h1);
    chk("edge_data", 32'(data_out_b), 32'h5A);
    chk("edge_err", 32'(err_b), 32'h0);
    bank_ready = 4'b0000;
    step();

    // Write timeout with clear_error held: set wins, data_out untouched
    clear_error = 1'b1;
    bus_enable_b = 1'b1; write_enable = 1'b1; address = 16'hC002; data_in = 8'h99;
    step();
    chk("wto_we_access", 32'(we_b), 32'h8);
    bus_enable_b = 1'b0; write_enable = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("wto_ready", 32'(ready_b), 32'h1);
    chk("wto_err_set_wins", 32'(err_b), 32'h1);
    chk("wto_data_hold", 32'(data_out_b), 32'h5A);
    step();
    chk("wto_err_clear", 32'(err_b), 32'h0);
    clear_error = 1'b0;

    // Reset during WAIT, then a normal request
    bus_enable_a = 1'b1; address = 16'hC003;
    step();
    bus_enable_a = 1'b0;
    step();
    step();
    chk("rw_sel_before", 32'(sel_a), 32'h8);
    reset = 1'b0;
    #1;
    chk("rw_sel", 32'(sel_a), 32'h0);
    chk("rw_ready", 32'(ready_a), 32'h0);
    chk("rw_data", 32'(data_out_a), 32'h0);
    chk("rw_baddr", 32'(baddr_a), 32'h0);
    step();
    reset = 1'b1;
    step();
    chk("rw_no_pulse1", 32'(ready_a), 32'h0);
    step();
    chk("rw_no_pulse2", 32'(ready_a), 32'h0);
    chk("rw_idle_sel", 32'(sel_a), 32'h0);
    bus_enable_a = 1'b1; address = 16'h4007;
    step();
    chk("rw_next_sel", 32'(sel_a), 32'h2);
    bus_enable_a = 1'b0;
    step();
    chk("rw_next_ready", 32'(ready_a), 32'h1);
    chk("rw_next_data", 32'(data_out_a), 32'h11);
    step();

    // Back-to-back: bus_enable held through DONE
    bus_enable_a = 1'b1; address = 16'h0001;
    step();
    address = 16'h4002;
    step();
    chk("b2b_ready1", 32'(ready_a), 32'h1);
    chk("b2b_data1", 32'(data_out_a), 32'hA5);
    step();
    chk("b2b_idle_sel", 32'(sel_a), 32'h0);
    chk("b2b_idle_ready", 32'(ready_a), 32'h0);
    step();
    chk("b2b_sel2", 32'(sel_a), 32'h2);
    chk("b2b_baddr2", 32'(baddr_a), 32'h0002);
    bus_enable_a = 1'b0;
    step();
    chk("b2b_ready2", 32'(ready_a), 32'h1);
    chk("b2b_data2", 32'(data_out_a), 32'h11);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
